// File: rtl/slave_cpl_tag_tracker.sv
// rtl/slave_cpl_tag_tracker.sv - completion tag tracker: recorder lookup, DW accounting, AXI response and tag release
module slave_cpl_tag_tracker #(
  parameter int ADDR_W  = 5,
  parameter int ID_W    = 4,
  parameter int LEN_W   = 10,
  parameter int ENTRY_W = 1 + ID_W + LEN_W
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic               cpl_valid,
  output logic               cpl_ready,
  input  logic [ADDR_W-1:0]  cpl_tag,
  input  logic [2:0]         cpl_status,
  input  logic [LEN_W-1:0]   cpl_dw_count,
  output logic [ADDR_W-1:0]  resp_rd_addr,
  input  logic [ENTRY_W-1:0] resp_rd_data,
  output logic               resp_wr_en,
  output logic [ADDR_W-1:0]  resp_wr_addr,
  output logic [ENTRY_W-1:0] resp_wr_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic               rsp_last,
  output logic               rsp_err,
  output logic               tag_free_valid,
  output logic [ADDR_W-1:0]  tag_free,
  output logic [7:0]         unexp_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic               cpl_ready_q, cpl_ready_d;
  logic [ADDR_W-1:0]  tag_q, tag_d;
  logic [2:0]         status_q, status_d;
  logic [LEN_W-1:0]   dw_q, dw_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [ENTRY_W-1:0] wr_data_q, wr_data_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic               rsp_last_q, rsp_last_d;
  logic               rsp_err_q, rsp_err_d;
  logic               free_valid_q, free_valid_d;
  logic [ADDR_W-1:0]  free_tag_q, free_tag_d;
  logic [7:0]         unexp_q, unexp_d;

  logic               ent_valid;
  logic [ID_W-1:0]    ent_id;
  logic [LEN_W-1:0]   ent_len;

  assign ent_valid = resp_rd_data[ENTRY_W-1];
  assign ent_id    = resp_rd_data[ID_W+LEN_W-1:LEN_W];
  assign ent_len   = resp_rd_data[LEN_W-1:0];

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    status_d     = status_q;
    dw_d         = dw_q;
    rd_addr_d    = rd_addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_last_d   = rsp_last_q;
    rsp_err_d    = rsp_err_q;
    free_valid_d = 1'b0;
    free_tag_d   = free_tag_q;
    unexp_d      = unexp_q;

    case (state_q)
      S_IDLE: begin
        if (cpl_valid && cpl_ready_q) begin
          tag_d     = cpl_tag;
          status_d  = cpl_status;
          dw_d      = cpl_dw_count;
          rd_addr_d = cpl_tag;
          state_d   = S_LOOKUP;
        end
      end
      S_LOOKUP: state_d = S_UPDATE;
      S_UPDATE: begin
        if (!ent_valid) begin
          // Completion for a tag nobody is waiting on: count it and drop it.
          if (unexp_q != 8'hFF) unexp_d = unexp_q + 8'd1;
          state_d = S_IDLE;
        end else begin
          wr_en_d     = 1'b1;
          wr_addr_d   = tag_q;
          rsp_valid_d = 1'b1;
          rsp_id_d    = ent_id;
          state_d     = S_RESP;
          if (status_q != 3'b000) begin
            wr_data_d  = {1'b0, ent_id, ent_len};
            rsp_last_d = 1'b1;
            rsp_err_d  = 1'b1;
          end else if (dw_q >= ent_len) begin
            wr_data_d  = {1'b0, ent_id, {LEN_W{1'b0}}};
            rsp_last_d = 1'b1;
            rsp_err_d  = 1'b0;
          end else begin
            wr_data_d  = {1'b1, ent_id, ent_len - dw_q};
            rsp_last_d = 1'b0;
            rsp_err_d  = 1'b0;
          end
        end
      end
      default: begin
        if (rsp_ready) begin
          rsp_valid_d  = 1'b0;
          free_valid_d = rsp_last_q;
          free_tag_d   = tag_q;
          state_d      = S_IDLE;
        end
      end
    endcase

    cpl_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= S_IDLE;
      cpl_ready_q  <= 1'b0;
      tag_q        <= '0;
      status_q     <= '0;
      dw_q         <= '0;
      rd_addr_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_last_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      free_valid_q <= 1'b0;
      free_tag_q   <= '0;
      unexp_q      <= '0;
    end else begin
      state_q      <= state_d;
      cpl_ready_q  <= cpl_ready_d;
      tag_q        <= tag_d;
      status_q     <= status_d;
      dw_q         <= dw_d;
      rd_addr_q    <= rd_addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_last_q   <= rsp_last_d;
      rsp_err_q    <= rsp_err_d;
      free_valid_q <= free_valid_d;
      free_tag_q   <= free_tag_d;
      unexp_q      <= unexp_d;
    end
  end

  assign cpl_ready      = cpl_ready_q;
  assign resp_rd_addr   = rd_addr_q;
  assign resp_wr_en     = wr_en_q;
  assign resp_wr_addr   = wr_addr_q;
  assign resp_wr_data   = wr_data_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_id         = rsp_id_q;
  assign rsp_last       = rsp_last_q;
  assign rsp_err        = rsp_err_q;
  assign tag_free_valid = free_valid_q;
  assign tag_free       = free_tag_q;
  assign unexp_cnt      = unexp_q;

endmodule

// File: tb/tb_slave_cpl_tag_tracker.sv
// tb/tb_slave_cpl_tag_tracker.sv - directed and randomized bench for slave_cpl_tag_tracker
module tb_slave_cpl_tag_tracker;
  localparam int ADDR_W  = 5;
  localparam int ID_W    = 4;
  localparam int LEN_W   = 10;
  localparam int ENTRY_W = 1 + ID_W + LEN_W;

  logic               ACLK = 1'b0;
  logic               ARESETn = 1'b0;
  logic               cpl_valid = 1'b0;
  logic               cpl_ready;
  logic [ADDR_W-1:0]  cpl_tag = '0;
  logic [2:0]         cpl_status = '0;
  logic [LEN_W-1:0]   cpl_dw_count = '0;
  logic [ADDR_W-1:0]  resp_rd_addr;
  logic [ENTRY_W-1:0] resp_rd_data;
  logic               resp_wr_en;
  logic [ADDR_W-1:0]  resp_wr_addr;
  logic [ENTRY_W-1:0] resp_wr_data;
  logic               rsp_valid;
  logic               rsp_ready = 1'b1;
  logic [ID_W-1:0]    rsp_id;
  logic               rsp_last;
  logic               rsp_err;
  logic               tag_free_valid;
  logic [ADDR_W-1:0]  tag_free;
  logic [7:0]         unexp_cnt;

  always #5 ACLK = ~ACLK;

  slave_cpl_tag_tracker #(
    .ADDR_W(ADDR_W), .ID_W(ID_W), .LEN_W(LEN_W), .ENTRY_W(ENTRY_W)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_tag(cpl_tag),
    .cpl_status(cpl_status), .cpl_dw_count(cpl_dw_count),
    .resp_rd_addr(resp_rd_addr), .resp_rd_data(resp_rd_data),
    .resp_wr_en(resp_wr_en), .resp_wr_addr(resp_wr_addr), .resp_wr_data(resp_wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_last(rsp_last), .rsp_err(rsp_err),
    .tag_free_valid(tag_free_valid), .tag_free(tag_free), .unexp_cnt(unexp_cnt)
  );

  // Recorder memory: synchronous read, DUT write port plus a bench preload port.
  logic [ENTRY_W-1:0] rec_mem [32];
  logic               clr_mem = 1'b0;
  logic               pre_en = 1'b0;
  logic [ADDR_W-1:0]  pre_addr = '0;
  logic [ENTRY_W-1:0] pre_data = '0;

  always @(posedge ACLK) begin
    if (clr_mem) begin
      for (int i = 0; i < 32; i++) rec_mem[i] <= '0;
    end else begin
      if (resp_wr_en) rec_mem[resp_wr_addr] <= resp_wr_data;
      if (pre_en) rec_mem[pre_addr] <= pre_data;
    end
    resp_rd_data <= rec_mem[resp_rd_addr];
  end

  // Reference model of the recorder table as seen by the tracker.
  bit sh_valid [32];
  int sh_id    [32];
  int sh_len   [32];
  int unexp_m;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
  endtask

  task automatic preload(input int tag, input int id, input int len);
    pre_en   = 1'b1;
    pre_addr = ADDR_W'(tag);
    pre_data = {1'b1, ID_W'(id), LEN_W'(len)};
    @(posedge ACLK);
    #1 pre_en = 1'b0;
    sh_valid[tag] = 1'b1;
    sh_id[tag]    = id;
    sh_len[tag]   = len;
    @(negedge ACLK);
  endtask

  // Issues one completion from a negedge and returns at a negedge with the DUT back in IDLE.
  task automatic do_cpl(input int tag, input int st, input int dw, input int hold);
    bit e_inv, e_last, e_err, e_vnew;
    int e_id, e_lnew;
    logic [ENTRY_W-1:0] e_word;
    e_inv = 0; e_last = 0; e_err = 0; e_vnew = 0; e_id = 0; e_lnew = 0;
    if (!sh_valid[tag]) begin
      e_inv = 1;
      if (unexp_m < 255) unexp_m++;
    end else begin
      e_id  = sh_id[tag];
      e_err = (st != 0);
      if (st != 0) begin
        e_last = 1; e_vnew = 0; e_lnew = sh_len[tag];
      end else if (dw >= sh_len[tag]) begin
        e_last = 1; e_vnew = 0; e_lnew = 0;
      end else begin
        e_last = 0; e_vnew = 1; e_lnew = sh_len[tag] - dw;
      end
    end
    e_word = {1'(e_vnew), ID_W'(e_id), LEN_W'(e_lnew)};

    chk("cpl_ready_idle", 32'(cpl_ready), 1);
    cpl_valid    = 1'b1;
    cpl_tag      = ADDR_W'(tag);
    cpl_status   = 3'(st);
    cpl_dw_count = LEN_W'(dw);
    rsp_ready    = (hold == 0);
    @(posedge ACLK);
    #1 cpl_valid = 1'b0;
    @(negedge ACLK);
    chk("cpl_ready_lookup", 32'(cpl_ready), 0);
    chk("rd_addr", 32'(resp_rd_addr), tag);
    @(negedge ACLK);
    chk("update_quiet", 32'({rsp_valid, resp_wr_en}), 0);
    @(negedge ACLK);
    if (e_inv) begin
      chk("unexp_no_rsp", 32'({rsp_valid, resp_wr_en, cpl_ready}), 32'b001);
      chk("unexp_cnt", 32'(unexp_cnt), unexp_m);
      chk("unexp_entry", 32'(rec_mem[tag][ENTRY_W-1]), 0);
    end else begin
      chk("rsp_valid", 32'(rsp_valid), 1);
      chk("wr_en", 32'(resp_wr_en), 1);
      chk("wr_addr", 32'(resp_wr_addr), tag);
      chk("wr_data", 32'(resp_wr_data), 32'(e_word));
      chk("rsp_fields", 32'({rsp_id, rsp_last, rsp_err, cpl_ready}),
          32'({ID_W'(e_id), 1'(e_last), 1'(e_err), 1'b0}));
      for (int k = 0; k < hold; k++) begin
        @(negedge ACLK);
        chk("hold_stable",
            32'({rsp_valid, rsp_id, rsp_last, rsp_err, cpl_ready, resp_wr_en, tag_free_valid}),
            32'({1'b1, ID_W'(e_id), 1'(e_last), 1'(e_err), 1'b0, 1'b0, 1'b0}));
      end
      rsp_ready = 1'b1;
      @(negedge ACLK);
      chk("rsp_done", 32'({rsp_valid, cpl_ready}), 32'b01);
      chk("tag_free_valid", 32'(tag_free_valid), 32'(e_last));
      if (e_last) chk("tag_free", 32'(tag_free), tag);
      chk("rec_entry", 32'(rec_mem[tag]), 32'(e_word));
      chk("unexp_hold", 32'(unexp_cnt), unexp_m);
      sh_valid[tag] = e_vnew;
      sh_len[tag]   = e_lnew;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int tag, st, dw, hold;
    logic [ENTRY_W-1:0] saved;
    for (int i = 0; i < 32; i++) begin
      sh_valid[i] = 0; sh_id[i] = 0; sh_len[i] = 0;
    end
    unexp_m = 0;
    clr_mem = 1'b1;
    repeat (3) @(negedge ACLK);
    chk("reset_ctrl", 32'({cpl_ready, resp_wr_en, rsp_valid, tag_free_valid, unexp_cnt}), 0);
    chk("reset_data", 32'({resp_rd_addr, resp_wr_addr, resp_wr_data, tag_free}), 0);
    chk("reset_rsp", 32'({rsp_id, rsp_last, rsp_err}), 0);
    clr_mem = 1'b0;
    ARESETn = 1'b1;
    @(negedge ACLK);

    preload(3, 5, 16);
    do_cpl(3, 0, 16, 0);

    preload(7, 2, 32);
    do_cpl(7, 0, 16, 0);
    do_cpl(7, 0, 16, 0);

    preload(1, 9, 8);
    do_cpl(1, 1, 4, 0);

    do_cpl(4, 0, 2, 0);

    preload(12, 6, 10);
    do_cpl(12, 0, 0, 5);
    do_cpl(12, 0, 10, 0);

    // Reset asserted while the tracker sits in UPDATE.
    preload(10, 3, 20);
    saved = rec_mem[10];
    cpl_valid = 1'b1; cpl_tag = 5'd10; cpl_status = 3'd0; cpl_dw_count = 10'd20;
    @(posedge ACLK);
    #1 cpl_valid = 1'b0;
    @(posedge ACLK);
    #1 ARESETn = 1'b0;
    #1;
    chk("midrst_ctrl", 32'({cpl_ready, resp_wr_en, rsp_valid, tag_free_valid, unexp_cnt}), 0);
    repeat (2) begin
      @(negedge ACLK);
      chk("midrst_no_wr", 32'(resp_wr_en), 0);
    end
    chk("midrst_entry", 32'(rec_mem[10]), 32'(saved));
    ARESETn = 1'b1;
    unexp_m = 0;
    @(negedge ACLK);
    do_cpl(10, 0, 20, 0);

    repeat (300) do_cpl(4, 0, 1, 0);
    chk("unexp_sat", 32'(unexp_cnt), 255);

    for (int n = 0; n < 60; n++) begin
      tag = int'($urandom_range(0, 31));
      if (!sh_valid[tag] && ($urandom_range(0, 3) != 0))
        preload(tag, int'($urandom_range(0, 15)), int'($urandom_range(1, 64)));
      st   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 7)) : 0;
      dw   = int'($urandom_range(0, 40));
      hold = int'($urandom_range(0, 3));
      do_cpl(tag, st, dw, hold);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
